// File: rtl/seg_pkg.sv
// Seven-segment pattern constants and reverse decode shared by the display encoder
// and the capture side. Bit order: seg[6]=a, seg[5]=b ... seg[0]=g, active-high.
package seg_pkg;

    localparam logic [6:0] SEG_0     = 7'b1111110;
    localparam logic [6:0] SEG_1     = 7'b0110000;
    localparam logic [6:0] SEG_2     = 7'b1101101;
    localparam logic [6:0] SEG_3     = 7'b1111001;
    localparam logic [6:0] SEG_4     = 7'b0110011;
    localparam logic [6:0] SEG_5     = 7'b1011011;
    localparam logic [6:0] SEG_6     = 7'b1011111;
    localparam logic [6:0] SEG_7     = 7'b1110000;
    localparam logic [6:0] SEG_8     = 7'b1111111;
    localparam logic [6:0] SEG_9     = 7'b1111011;
    localparam logic [6:0] SEG_9_ALT = 7'b1110011;
    localparam logic [6:0] SEG_A     = 7'b1110111;
    localparam logic [6:0] SEG_B     = 7'b0011111;
    localparam logic [6:0] SEG_C     = 7'b1001110;
    localparam logic [6:0] SEG_D     = 7'b0111101;
    localparam logic [6:0] SEG_E     = 7'b1001111;
    localparam logic [6:0] SEG_F     = 7'b1000111;

    // Returns {recognised, nibble}; any pattern outside the table (including blank) is unrecognised.
    function automatic logic [4:0] seg_to_hex(input logic [6:0] s);
        case (s)
            SEG_0:     return {1'b1, 4'h0};
            SEG_1:     return {1'b1, 4'h1};
            SEG_2:     return {1'b1, 4'h2};
            SEG_3:     return {1'b1, 4'h3};
            SEG_4:     return {1'b1, 4'h4};
            SEG_5:     return {1'b1, 4'h5};
            SEG_6:     return {1'b1, 4'h6};
            SEG_7:     return {1'b1, 4'h7};
            SEG_8:     return {1'b1, 4'h8};
            SEG_9:     return {1'b1, 4'h9};
            SEG_9_ALT: return {1'b1, 4'h9};
            SEG_A:     return {1'b1, 4'hA};
            SEG_B:     return {1'b1, 4'hB};
            SEG_C:     return {1'b1, 4'hC};
            SEG_D:     return {1'b1, 4'hD};
            SEG_E:     return {1'b1, 4'hE};
            SEG_F:     return {1'b1, 4'hF};
            default:   return 5'b0_0000;
        endcase
    endfunction

endpackage

// File: rtl/seg_pattern_decode.sv
// Combinational lookup of a seven-segment pattern back to its hex nibble.
module seg_pattern_decode
    import seg_pkg::*;
(
    input  logic [6:0] seg,
    output logic       recognised,
    output logic [3:0] nibble
);

    always_comb begin
        {recognised, nibble} = seg_to_hex(seg);
    end

endmodule

// File: rtl/seg_scan_capture.sv
// Samples a multiplexed seven-segment bus, waits for a stable scan slot and
// rebuilds the displayed hex digits, flagging unrecognised patterns.
module seg_scan_capture
    import seg_pkg::*;
#(
    parameter int DIGITS        = 4,
    parameter int STABLE_CYCLES = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [DIGITS-1:0]     dig_sel,
    input  logic [6:0]            seg,
    output logic [4*DIGITS-1:0]   value,
    output logic [DIGITS-1:0]     digit_valid,
    output logic                  frame_valid,
    output logic                  err,
    output logic [2:0]            err_digit
);

    localparam int SW = DIGITS + 7;
    localparam int CW = $clog2(STABLE_CYCLES + 1);
    localparam logic [CW-1:0] CMAX = CW'(STABLE_CYCLES);

    logic [SW-1:0]       s1, s2;
    logic [CW-1:0]       cnt, cnt_nxt;
    logic                accept;
    logic [DIGITS-1:0]   dig;
    logic [6:0]          pat;
    logic                rec;
    logic [3:0]          nib;
    logic [4*DIGITS-1:0] value_nxt;
    logic [DIGITS-1:0]   dv_nxt;
    logic                frame_nxt;
    logic                err_nxt;
    logic [2:0]          err_digit_nxt;

    assign dig = s2[SW-1:7];
    assign pat = s2[6:0];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1 <= '0;
            s2 <= '0;
        end else begin
            s1 <= {dig_sel, seg};
            s2 <= s1;
        end
    end

    // s1 is the value s2 takes next, so a mismatch means s2 is about to change;
    // this lets the accept land STABLE_CYCLES edges after s2 first holds the pattern.
    always_comb begin
        if (s1 != s2)
            cnt_nxt = '0;
        else if (cnt == CMAX)
            cnt_nxt = cnt;
        else
            cnt_nxt = cnt + CW'(1);
    end

    assign accept = (cnt_nxt == CMAX) && (cnt != CMAX);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            cnt <= '0;
        else
            cnt <= cnt_nxt;
    end

    seg_pattern_decode u_decode (
        .seg        (pat),
        .recognised (rec),
        .nibble     (nib)
    );

    // Zero or multi-hot strobes are scan transitions and are ignored silently.
    always_comb begin
        value_nxt     = value;
        dv_nxt        = digit_valid;
        err_nxt       = 1'b0;
        err_digit_nxt = err_digit;
        frame_nxt     = 1'b0;
        if (accept && $onehot(dig)) begin
            for (int i = 0; i < DIGITS; i++) begin
                if (dig[i]) begin
                    if (rec) begin
                        value_nxt[4*i +: 4] = nib;
                        dv_nxt[i]           = 1'b1;
                    end else begin
                        dv_nxt[i]     = 1'b0;
                        err_nxt       = 1'b1;
                        err_digit_nxt = 3'(i);
                    end
                end
            end
            frame_nxt = rec && dig[DIGITS-1] && (&dv_nxt);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            value       <= '0;
            digit_valid <= '0;
            frame_valid <= 1'b0;
            err         <= 1'b0;
            err_digit   <= '0;
        end else begin
            value       <= value_nxt;
            digit_valid <= dv_nxt;
            frame_valid <= frame_nxt;
            err         <= err_nxt;
            err_digit   <= err_digit_nxt;
        end
    end

endmodule

// File: tb/tb_seg_scan_capture.sv
// Directed bench for seg_scan_capture: reset, latency, vector table, glitch and reset-abort sequences.
module tb_seg_scan_capture;

    logic        clk;
    logic        rst_n;
    logic [3:0]  dig_sel;
    logic [6:0]  seg;
    logic [15:0] value;
    logic [3:0]  digit_valid;
    logic        frame_valid;
    logic        err;
    logic [2:0]  err_digit;

    int checks = 0;
    int errors = 0;
    int frame_cnt = 0;
    int err_cnt = 0;

    typedef struct {
        logic [3:0]  ds;
        logic [6:0]  sg;
        int          hold;
        logic [15:0] exp_val;
        logic [3:0]  exp_dv;
        int          exp_frames;
        int          exp_errs;
        logic [2:0]  exp_ed;
    } vec_t;

    vec_t vecs[17];

    seg_scan_capture #(.DIGITS(4), .STABLE_CYCLES(4)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .dig_sel     (dig_sel),
        .seg         (seg),
        .value       (value),
        .digit_valid (digit_valid),
        .frame_valid (frame_valid),
        .err         (err),
        .err_digit   (err_digit)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // pulse monitors, sampled away from the active edge
    always @(negedge clk) begin
        if (frame_valid) frame_cnt++;
        if (err) err_cnt++;
    end

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h expected=%0h", name, got, exp);
        end
    endtask

    task automatic drive(input logic [3:0] ds, input logic [6:0] sg);
        dig_sel = ds;
        seg     = sg;
    endtask

    task automatic wait_cycles(input int n);
        for (int i = 0; i < n; i++) @(negedge clk);
    endtask

    initial begin
        int f0, e0;

        vecs[0]  = '{4'b0001, 7'b1101101,  8, 16'h0002, 4'b0001, 0, 0, 3'd0};
        vecs[1]  = '{4'b0010, 7'b1110111,  8, 16'h00A2, 4'b0011, 0, 0, 3'd0};
        vecs[2]  = '{4'b0100, 7'b1000111,  8, 16'h0FA2, 4'b0111, 0, 0, 3'd0};
        vecs[3]  = '{4'b1000, 7'b1110011,  8, 16'h9FA2, 4'b1111, 1, 0, 3'd0};
        vecs[4]  = '{4'b1000, 7'b1001110, 50, 16'hCFA2, 4'b1111, 1, 0, 3'd0};
        vecs[5]  = '{4'b0000, 7'b0000000,  8, 16'hCFA2, 4'b1111, 0, 0, 3'd0};
        vecs[6]  = '{4'b0011, 7'b1111110,  8, 16'hCFA2, 4'b1111, 0, 0, 3'd0};
        vecs[7]  = '{4'b0001, 7'b0110011,  3, 16'hCFA2, 4'b1111, 0, 0, 3'd0};
        vecs[8]  = '{4'b0100, 7'b1011011,  8, 16'hC5A2, 4'b1111, 0, 0, 3'd0};
        vecs[9]  = '{4'b0100, 7'b0000001,  8, 16'hC5A2, 4'b1011, 0, 1, 3'd2};
        vecs[10] = '{4'b0100, 7'b1111011,  8, 16'hC9A2, 4'b1111, 0, 0, 3'd2};
        vecs[11] = '{4'b1000, 7'b1111110,  8, 16'h09A2, 4'b1111, 1, 0, 3'd2};
        vecs[12] = '{4'b0001, 7'b0000000,  8, 16'h09A2, 4'b1110, 0, 1, 3'd0};
        vecs[13] = '{4'b0001, 7'b0110011,  8, 16'h09A4, 4'b1111, 0, 0, 3'd0};
        vecs[14] = '{4'b0010, 7'b1111001,  8, 16'h0934, 4'b1111, 0, 0, 3'd0};
        vecs[15] = '{4'b0100, 7'b1101101,  8, 16'h0234, 4'b1111, 0, 0, 3'd0};
        vecs[16] = '{4'b1000, 7'b0110000,  8, 16'h1234, 4'b1111, 1, 0, 3'd0};

        // reset state
        rst_n = 1'b0;
        drive(4'b0000, 7'b0000000);
        wait_cycles(3);
        check("reset_value", 32'(value), 32'h0);
        check("reset_dv", 32'(digit_valid), 32'h0);
        check("reset_frame", 32'(frame_valid), 32'h0);
        check("reset_err", 32'(err), 32'h0);
        check("reset_err_digit", 32'(err_digit), 32'h0);
        rst_n = 1'b1;
        wait_cycles(2);

        // exact latency: update lands on the fifth edge after first sampling
        f0 = frame_cnt; e0 = err_cnt;
        drive(4'b0001, 7'b0110000);
        wait_cycles(5);
        check("lat_before_value", 32'(value), 32'h0);
        check("lat_before_dv", 32'(digit_valid), 32'h0);
        wait_cycles(1);
        check("lat_value", 32'(value), 32'h0001);
        check("lat_dv", 32'(digit_valid), 32'h1);
        wait_cycles(4);
        check("lat_hold_value", 32'(value), 32'h0001);
        check("lat_errs", 32'(err_cnt - e0), 32'h0);
        check("lat_frames", 32'(frame_cnt - f0), 32'h0);

        for (int i = 0; i < 17; i++) begin
            if (i == 4) begin
                // scan glitch: pattern flips every 2 cycles, never stable long enough
                f0 = frame_cnt; e0 = err_cnt;
                for (int j = 0; j < 10; j++) begin
                    drive(4'b0010, (j % 2 == 0) ? 7'b1111110 : 7'b0110000);
                    wait_cycles(2);
                end
                check("glitch_value", 32'(value), 32'h9FA2);
                check("glitch_dv", 32'(digit_valid), 32'hF);
                check("glitch_frames", 32'(frame_cnt - f0), 32'h0);
                check("glitch_errs", 32'(err_cnt - e0), 32'h0);
            end
            f0 = frame_cnt; e0 = err_cnt;
            drive(vecs[i].ds, vecs[i].sg);
            wait_cycles(vecs[i].hold);
            check($sformatf("vec%0d_value", i), 32'(value), 32'(vecs[i].exp_val));
            check($sformatf("vec%0d_dv", i), 32'(digit_valid), 32'(vecs[i].exp_dv));
            check($sformatf("vec%0d_frames", i), 32'(frame_cnt - f0), 32'(vecs[i].exp_frames));
            check($sformatf("vec%0d_errs", i), 32'(err_cnt - e0), 32'(vecs[i].exp_errs));
            check($sformatf("vec%0d_err_digit", i), 32'(err_digit), 32'(vecs[i].exp_ed));
        end

        // reset asserted mid-capture clears everything at once
        drive(4'b0001, 7'b1111111);
        wait_cycles(3);
        #2 rst_n = 1'b0;
        #1;
        check("midrst_value", 32'(value), 32'h0);
        check("midrst_dv", 32'(digit_valid), 32'h0);
        check("midrst_frame", 32'(frame_valid), 32'h0);
        check("midrst_err", 32'(err), 32'h0);
        wait_cycles(3);
        rst_n = 1'b1;
        f0 = frame_cnt; e0 = err_cnt;
        wait_cycles(3);
        drive(4'b0000, 7'b0000000);
        wait_cycles(8);
        check("post_rst_value", 32'(value), 32'h0);
        check("post_rst_dv", 32'(digit_valid), 32'h0);
        check("post_rst_pulses", 32'((frame_cnt - f0) + (err_cnt - e0)), 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout got=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
